// File: rtl/tetris_pkg.sv
// Shared board geometry and the line-clear state encoding, so game-logic
// debug LEDs can decode the engine state.
package tetris_pkg;

   localparam int BOARD_COLS = 10;
   localparam int BOARD_ROWS = 20;
   localparam int X_W        = 4;
   localparam int Y_W        = 5;

   typedef enum logic [2:0] {
      LC_IDLE    = 3'd0,
      LC_SCAN    = 3'd1,
      LC_SHIFT   = 3'd2,
      LC_CLR_TOP = 3'd3,
      LC_DONE    = 3'd4
   } lc_state_t;

endpackage

// File: rtl/line_clear_if.sv
// Board memory access bus: combinational read port plus one write port.
interface line_clear_if;
   import tetris_pkg::*;

   logic           board_rdata;
   logic [X_W-1:0] board_rx;
   logic [Y_W-1:0] board_ry;
   logic           board_we;
   logic [X_W-1:0] board_wx;
   logic [Y_W-1:0] board_wy;
   logic           board_wdata;

   modport master (
      input  board_rdata,
      output board_rx, board_ry, board_we, board_wx, board_wy, board_wdata
   );

   modport slave (
      output board_rdata,
      input  board_rx, board_ry, board_we, board_wx, board_wy, board_wdata
   );

endinterface

// File: rtl/line_clear.sv
// Line-clear engine: scans the board bottom-up, collapses every full row by
// copying the rows above it down one cell per cycle, and counts removed lines.
module line_clear
   import tetris_pkg::*;
#(
   parameter int COLS = BOARD_COLS,
   parameter int ROWS = BOARD_ROWS
) (
   input  logic         CLOCK_50,
   input  logic         resetn,
   input  logic         start,
   line_clear_if.master board,
   output logic         busy,
   output logic         done,
   output logic [4:0]   lines_cleared,
   output logic [7:0]   lines_total
);

   localparam logic [X_W-1:0] X_LAST = X_W'(COLS - 1);
   localparam logic [Y_W-1:0] Y_LAST = Y_W'(ROWS - 1);

   lc_state_t      state, state_n;
   logic [X_W-1:0] x, x_n;
   logic [Y_W-1:0] y, y_n;
   logic [Y_W-1:0] r, r_n;
   logic [4:0]     cleared_n;
   logic [7:0]     total_n;

   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         state         <= LC_IDLE;
         x             <= '0;
         y             <= '0;
         r             <= '0;
         lines_cleared <= '0;
         lines_total   <= '0;
      end else begin
         state         <= state_n;
         x             <= x_n;
         y             <= y_n;
         r             <= r_n;
         lines_cleared <= cleared_n;
         lines_total   <= total_n;
      end
   end

   always_comb begin
      state_n           = state;
      x_n               = x;
      y_n               = y;
      r_n               = r;
      cleared_n         = lines_cleared;
      total_n           = lines_total;
      busy              = 1'b0;
      done              = 1'b0;
      board.board_rx    = '0;
      board.board_ry    = '0;
      board.board_we    = 1'b0;
      board.board_wx    = '0;
      board.board_wy    = '0;
      board.board_wdata = 1'b0;

      case (state)
         LC_IDLE: begin
            if (start) begin
               state_n   = LC_SCAN;
               x_n       = '0;
               y_n       = Y_LAST;
               cleared_n = '0;
            end
         end

         // An empty cell ends the row early; reaching the last column means full.
         LC_SCAN: begin
            busy           = 1'b1;
            board.board_rx = x;
            board.board_ry = y;
            if (!board.board_rdata) begin
               x_n = '0;
               if (y == '0) begin
                  state_n = LC_DONE;
               end else begin
                  y_n = y - 1'b1;
               end
            end else if (x != X_LAST) begin
               x_n = x + 1'b1;
            end else begin
               cleared_n = lines_cleared + 5'd1;
               if (lines_total != 8'hFF) begin
                  total_n = lines_total + 8'd1;
               end
               r_n     = y;
               x_n     = '0;
               state_n = (y == '0) ? LC_CLR_TOP : LC_SHIFT;
            end
         end

         LC_SHIFT: begin
            busy              = 1'b1;
            board.board_rx    = x;
            board.board_ry    = r - 1'b1;
            board.board_we    = 1'b1;
            board.board_wx    = x;
            board.board_wy    = r;
            board.board_wdata = board.board_rdata;
            if (x == X_LAST) begin
               x_n = '0;
               if (r == Y_W'(1)) begin
                  state_n = LC_CLR_TOP;
               end else begin
                  r_n = r - 1'b1;
               end
            end else begin
               x_n = x + 1'b1;
            end
         end

         // After clearing the top row, rescan the same y: the row that moved down may be full.
         LC_CLR_TOP: begin
            busy              = 1'b1;
            board.board_we    = 1'b1;
            board.board_wx    = x;
            board.board_wy    = '0;
            board.board_wdata = 1'b0;
            if (x == X_LAST) begin
               x_n     = '0;
               state_n = LC_SCAN;
            end else begin
               x_n = x + 1'b1;
            end
         end

         LC_DONE: begin
            done    = 1'b1;
            state_n = LC_IDLE;
         end

         default: begin
            state_n = LC_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_line_clear.sv
// Self-checking bench for line_clear: a behavioural board memory, a row-level
// reference model, directed spec cases and randomized boards.
module tb_line_clear;

   localparam int COLS   = 10;
   localparam int ROWS   = 20;
   localparam int BUDGET = 6000;
   localparam logic [COLS-1:0] FULL = {COLS{1'b1}};

   logic       clk;
   logic       resetn;
   logic       start;
   logic       busy;
   logic       done;
   logic [4:0] lines_cleared;
   logic [7:0] lines_total;

   line_clear_if bus();

   line_clear dut (
      .CLOCK_50      (clk),
      .resetn        (resetn),
      .start         (start),
      .board         (bus),
      .busy          (busy),
      .done          (done),
      .lines_cleared (lines_cleared),
      .lines_total   (lines_total)
   );

   logic [COLS-1:0] mem      [ROWS];
   logic [COLS-1:0] load_img [ROWS];
   logic [COLS-1:0] init_img [ROWS];
   logic [COLS-1:0] exp_img  [ROWS];
   logic            load_en;

   int checks;
   int errors;
   int exp_lines;
   int exp_cycles;
   int exp_writes;
   int exp_total;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (load_en) begin
         mem <= load_img;
      end else if (bus.board_we) begin
         mem[bus.board_wy][bus.board_wx] <= bus.board_wdata;
      end
   end

   assign bus.board_rdata = (int'(bus.board_ry) < ROWS && int'(bus.board_rx) < COLS)
                            ? mem[bus.board_ry][bus.board_rx] : 1'b0;

   task automatic checkOutput(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Expected board is the surviving rows packed to the bottom; timing walks the rows.
   task automatic computeExpected();
      logic [COLS-1:0] work [ROWS];
      int n;
      int y;
      int k;
      exp_lines  = 0;
      exp_cycles = 0;
      exp_writes = 0;
      for (int i = 0; i < ROWS; i++) begin
         exp_img[i] = '0;
         work[i]    = init_img[i];
      end
      n = ROWS - 1;
      for (int i = ROWS - 1; i >= 0; i--) begin
         if (init_img[i] == FULL) begin
            exp_lines++;
         end else begin
            exp_img[n] = init_img[i];
            n--;
         end
      end
      y = ROWS - 1;
      for (int guard = 0; guard < 1000; guard++) begin
         if (work[y] == FULL) begin
            exp_cycles += COLS + COLS * y + COLS;
            exp_writes += COLS * y + COLS;
            for (int j = y; j > 0; j--) work[j] = work[j-1];
            work[0] = '0;
         end else begin
            k = COLS - 1;
            for (int i = COLS - 1; i >= 0; i--) if (!work[y][i]) k = i;
            exp_cycles += k + 1;
            if (y == 0) break;
            y--;
         end
      end
      exp_total = (exp_total + exp_lines > 255) ? 255 : exp_total + exp_lines;
   endtask

   task automatic loadBoard();
      load_img = init_img;
      @(posedge clk); #1 load_en = 1'b1;
      @(posedge clk); #1 load_en = 1'b0;
   endtask

   task automatic applyStimulus(input bit poke, output int done_cyc,
                                output int busy_cnt, output int write_cnt);
      int cyc;
      done_cyc  = -1;
      busy_cnt  = 0;
      write_cnt = 0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      cyc = 1;
      while (done_cyc < 0 && cyc <= BUDGET) begin
         if (done) begin
            done_cyc = cyc;
         end else begin
            if (busy) busy_cnt++;
            if (bus.board_we) write_cnt++;
            start = (poke && (cyc == 5 || cyc == 40));
            @(posedge clk); #1;
            cyc++;
         end
      end
      start = 1'b0;
      if (done_cyc < 0) checkOutput("done_timeout", 0, 1);
   endtask

   task automatic runCase(input string name, input int const_done, input bit poke);
      int dc;
      int bc;
      int wc;
      loadBoard();
      computeExpected();
      applyStimulus(poke, dc, bc, wc);
      if (const_done >= 0) checkOutput({name, "_done_const"}, dc, const_done);
      checkOutput({name, "_done_cycle"}, dc, exp_cycles + 1);
      checkOutput({name, "_busy_cycles"}, bc, exp_cycles);
      checkOutput({name, "_writes"}, wc, exp_writes);
      checkOutput({name, "_cleared"}, int'(lines_cleared), exp_lines);
      checkOutput({name, "_total"}, int'(lines_total), exp_total);
      checkOutput({name, "_busy_at_done"}, int'(busy), 0);
      for (int i = 0; i < ROWS; i++)
         checkOutput($sformatf("%s_row%0d", name, i), int'(mem[i]), int'(exp_img[i]));
   endtask

   initial begin
      int dc;
      int bc;
      int wc;
      int extra;
      checks    = 0;
      errors    = 0;
      exp_total = 0;
      start     = 1'b0;
      load_en   = 1'b0;
      resetn    = 1'b0;
      for (int i = 0; i < ROWS; i++) init_img[i] = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_busy", int'(busy), 0);
      checkOutput("reset_done", int'(done), 0);
      checkOutput("reset_we", int'(bus.board_we), 0);
      checkOutput("reset_cleared", int'(lines_cleared), 0);
      checkOutput("reset_total", int'(lines_total), 0);
      resetn = 1'b1;

      runCase("empty", 21, 1'b0);
      checkOutput("empty_no_writes", exp_writes, 0);

      init_img[19] = FULL;
      runCase("row19", 231, 1'b0);

      for (int i = 0; i < ROWS; i++) init_img[i] = '0;
      init_img[18] = FULL;
      init_img[19] = FULL;
      init_img[17] = 10'b0000001000;
      runCase("rows18_19", -1, 1'b1);
      checkOutput("rows18_19_cleared_const", int'(lines_cleared), 2);
      checkOutput("rows18_19_row19_const", int'(mem[19]), 8);
      extra = 0;
      repeat (30) begin
         @(posedge clk); #1;
         if (done) extra++;
      end
      checkOutput("restart_extra_done", extra, 0);

      for (int i = 0; i < ROWS; i++) init_img[i] = '0;
      init_img[0] = FULL;
      runCase("row0", 41, 1'b0);

      for (int i = 0; i < ROWS; i++) init_img[i] = '0;
      init_img[19] = FULL;
      loadBoard();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (15) @(posedge clk);
      #1 resetn = 1'b0;
      @(posedge clk); #1;
      checkOutput("midreset_busy", int'(busy), 0);
      checkOutput("midreset_we", int'(bus.board_we), 0);
      checkOutput("midreset_done", int'(done), 0);
      checkOutput("midreset_cleared", int'(lines_cleared), 0);
      checkOutput("midreset_total", int'(lines_total), 0);
      resetn    = 1'b1;
      exp_total = 0;

      for (int t = 0; t < 12; t++) begin
         for (int i = 0; i < ROWS; i++) begin
            if (i < 4)
               init_img[i] = COLS'($urandom) & COLS'($urandom);
            else if ($urandom_range(0, 2) == 0)
               init_img[i] = FULL;
            else
               init_img[i] = FULL & ~(COLS'(1) << $urandom_range(0, COLS - 1));
         end
         runCase($sformatf("rand%0d", t), -1, 1'b0);
      end

      @(posedge clk); #1 resetn = 1'b0;
      @(posedge clk); #1 resetn = 1'b1;
      exp_total = 0;
      for (int i = 0; i < ROWS; i++) init_img[i] = '0;
      init_img[0] = FULL;
      for (int p = 0; p < 256; p++) begin
         loadBoard();
         computeExpected();
         applyStimulus(1'b0, dc, bc, wc);
         if (dc < 0) break;
         if (p == 253) checkOutput("sat_pass254", int'(lines_total), 254);
         if (p == 254) checkOutput("sat_pass255", int'(lines_total), 255);
      end
      checkOutput("sat_final", int'(lines_total), 255);
      checkOutput("sat_model", int'(lines_total), exp_total);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
